urv_writeback: RTL



---
 rtl/urv_writeback.sv | 72 +++++++
 1 files changed

// File: rtl/urv_writeback.sv
// urv_writeback: completes execute results and memory ops, drives register-file write, bypass, stall, fault and instret.
module urv_writeback #(
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        x_valid_i,
  input  logic [4:0]  x_rd_i,
  input  logic [31:0] x_rd_value_i,
  input  logic        x_rd_write_i,
  input  logic        x_load_i,
  input  logic        x_store_i,
  input  logic [2:0]  x_fun_i,
  input  logic [1:0]  x_dm_addr_i,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_load_done_i,
  input  logic        dm_store_done_i,
  output logic        w_stall_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_rd_value_o,
  output logic        rf_rd_write_o,
  output logic        bypass_rd_write_o,
  output logic [31:0] bypass_rd_value_o,
  output logic        w_fault_o,
  output logic [63:0] w_instret_o
);
  typedef enum logic {IDLE, WAIT_MEM} state_t;
  state_t state, state_nxt;
  logic [TIMEOUT_W-1:0] wcnt, wcnt_nxt;
  logic mem, done, abort, stall, rd_nz;
  logic [7:0] b;
  logic [15:0] h;
  logic [31:0] ld;
  assign mem   = x_valid_i & (x_load_i | x_store_i);
  assign done  = x_load_i ? dm_load_done_i : dm_store_done_i;
  assign abort = (TIMEOUT != 0) && state == WAIT_MEM && wcnt == TIMEOUT_W'(TIMEOUT) && !done;
  assign stall = mem & ~done & ~abort;
  assign rd_nz = x_rd_i != 5'd0;
  assign b     = dm_data_l_i[{x_dm_addr_i, 3'b000} +: 8];
  assign h     = x_dm_addr_i[1] ? dm_data_l_i[31:16] : dm_data_l_i[15:0];
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      wcnt        <= '0;
      w_fault_o   <= 1'b0;
      w_instret_o <= '0;
    end else begin
      state       <= state_nxt;
      wcnt        <= wcnt_nxt;
      w_fault_o   <= abort;
      w_instret_o <= w_instret_o + {63'd0, x_valid_i & ~stall};
    end
  end
  // wcnt counts cycles spent in WAIT_MEM; the first missed cycle in IDLE leaves it at zero
  always_comb begin
    state_nxt = stall ? WAIT_MEM : IDLE;
    wcnt_nxt  = (stall && state == WAIT_MEM) ? wcnt + 1'b1 : '0;
  end
  always_comb begin
    ld = x_fun_i == 3'b000 ? {{24{b[7]}}, b} :
         x_fun_i == 3'b100 ? {24'd0, b} :
         x_fun_i == 3'b001 ? {{16{h[15]}}, h} :
         x_fun_i == 3'b101 ? {16'd0, h} : dm_data_l_i;
    w_stall_o         = rst_i & stall;
    rf_rd_o           = rst_i ? x_rd_i : 5'd0;
    rf_rd_write_o     = rst_i & x_valid_i & rd_nz & (mem ? (x_load_i & done) : x_rd_write_i);
    rf_rd_value_o     = !rst_i ? 32'd0 : x_load_i ? ld : x_rd_value_i;
    bypass_rd_write_o = rst_i & x_valid_i & ~x_load_i & ~x_store_i & x_rd_write_i & rd_nz;
    bypass_rd_value_o = rst_i ? x_rd_value_i : 32'd0;
  end
endmodule
